ifetch_unit: RTL and testbench

- Instruction fetch front end that produces the `ins` stream consumed by the rv32i core top.
- Holds the PC and issues word-aligned read requests to the instruction memory over a valid/ready request channel.
- Accepts in-order responses, buffers them with their PCs in a small FIFO, and presents them to the core with a valid/ready handshake.
- Supports a redirect (branch/jump) input that flushes buffered and in-flight fetches.

---
 rtl/rv_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/ifetch_unit.sv | 102 ++++++++++
 tb/tb_ifetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I constants, fetch buffer entry type and PC helpers
package rv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    // Sequential PC; 32-bit arithmetic wraps FFFF_FFFC to 0 naturally
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

    // Force word alignment by clearing the two low address bits
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc, insn} buffer with flush and combinational head
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  fetch_entry_t           i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop   = i_pop && !o_empty && !i_flush;
    assign w_push  = i_push && !i_flush && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));

    // Pointer and occupancy tracking; a flush empties the buffer in one edge
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Entry storage needs no reset; only slots between the pointers are read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC, request gating, in-flight accounting and redirect flush
module ifetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]    r_pc;
    logic [31:0]    r_rsp_pc;
    logic [CW-1:0]  r_out;
    logic [CW-1:0]  r_drop;
    logic [FCW-1:0] w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_req_fire;
    logic           w_push;
    logic           w_pop;
    logic           w_rsp_drop;
    logic [31:0]    w_redirect_pc;
    fetch_entry_t   w_entry;
    fetch_entry_t   w_head;

    // Every kept in-flight request owns a FIFO slot, so pushes cannot overflow;
    // stale requests still occupy memory bandwidth and count against the cap
    assign req_valid = !rst && !redirect_valid
                     && (32'(w_count) + 32'(r_out) < 32'(FIFO_DEPTH))
                     && (32'(r_out) + 32'(r_drop) < 32'(MAX_OUTSTANDING));
    assign req_addr      = r_pc;
    assign w_req_fire    = req_valid && req_ready;
    assign w_rsp_drop    = rsp_valid && (r_drop != '0);
    assign w_push        = rsp_valid && (r_drop == '0) && !redirect_valid;
    assign w_pop         = ins_valid && ins_ready && !redirect_valid;
    assign w_redirect_pc = align_pc(redirect_pc);
    assign w_entry       = '{pc: r_rsp_pc, insn: rsp_data};

    assign ins_valid = !w_empty;
    assign ins       = w_empty ? NOP_INSN : w_head.insn;
    assign ins_pc    = w_empty ? 32'h0 : w_head.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // PC and in-flight accounting; redirect turns all kept requests into drops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_out    <= '0;
            r_drop   <= '0;
        end else if (redirect_valid) begin
            r_pc     <= w_redirect_pc;
            r_rsp_pc <= w_redirect_pc;
            r_out    <= '0;
            r_drop   <= r_drop + r_out - CW'(rsp_valid);
        end else begin
            if (w_req_fire) r_pc <= next_pc(r_pc);
            if (w_push) r_rsp_pc <= next_pc(r_rsp_pc);
            r_out  <= r_out + CW'(w_req_fire) - CW'(w_push);
            r_drop <= r_drop - CW'(w_rsp_drop);
        end
    end

    // Buffer overflow would mean the slot reservation has been broken
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full && !w_pop));

    // The memory may only answer requests that are actually in flight
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        rsp_valid |-> (32'(r_out) + 32'(r_drop) != 32'h0));

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenarios against an in-order latency memory model
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 1;
    int cyc = 0;
    logic [31:0] q_addr [$];
    int          q_due  [$];

    ifetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0070_0093;
            32'h4:   return 32'h00C0_0113;
            32'h8:   return 32'h0020_81B3;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // In-order memory: a request accepted at an edge answers lat cycles later
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            q_addr.delete();
            q_due.delete();
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
        end else begin
            if (req_valid && req_ready) begin
                q_addr.push_back(req_addr);
                q_due.push_back(cyc + lat - 1);
            end
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem_word(q_addr[0]);
                q_addr.delete(0);
                q_due.delete(0);
            end else begin
                rsp_valid <= 1'b0;
                rsp_data  <= 32'h0;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        lat = 1; req_ready = 1'b1; ins_ready = 1'b1; redirect_valid = 1'b0;
        rst = 1'b1;
        step();
        n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ins_valid got %b exp 0", ins_valid); end
        n_cmp++; if (ins !== 32'h0000_0013) begin n_bad++; $display("FAIL reset_ins got %h exp 00000013", ins); end
        n_cmp++; if (ins_pc !== 32'h0) begin n_bad++; $display("FAIL reset_ins_pc got %h exp 00000000", ins_pc); end
        n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid got %b exp 0", req_valid); end
        rst = 1'b0;
        #1;
        n_cmp++; if (req_valid !== 1'b1) begin n_bad++; $display("FAIL reset_first_req_valid got %b exp 1", req_valid); end
        n_cmp++; if (req_addr !== 32'h0) begin n_bad++; $display("FAIL reset_first_req_addr got %h exp 00000000", req_addr); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_ins [3];
        logic [31:0] exp_pc [3];
        exp_ins[0] = 32'h0070_0093; exp_ins[1] = 32'h00C0_0113; exp_ins[2] = 32'h0020_81B3;
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
        lat = 1; req_ready = 1'b1; ins_ready = 1'b1;
        do_reset();
        step();
        n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid got %b exp 0", ins_valid); end
        n_cmp++; if (req_addr !== 32'h4) begin n_bad++; $display("FAIL stream_req_addr got %h exp 00000004", req_addr); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({ins_valid, ins, ins_pc} !== {1'b1, exp_ins[i], exp_pc[i]}) begin
                n_bad++; $display("FAIL stream_%0d got v=%b %h/%h exp v=1 %h/%h", i, ins_valid, ins, ins_pc, exp_ins[i], exp_pc[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] got [$];
        logic [31:0] first_req;
        logic        have_req;
        lat = 1; req_ready = 1'b1; ins_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (req_valid && req_ready) got.push_back(req_addr);
            step();
        end
        n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL bp_req_count got %0d exp 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            n_cmp++; if (got[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL bp_req_addr_%0d got %h exp %h", i, got[i], 32'(4 * i)); end
        end
        n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_full_req_valid got %b exp 0", req_valid); end
        ins_ready = 1'b1;
        #1;
        have_req = 1'b0;
        first_req = 32'h0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({ins_valid, ins_pc, ins} !== {1'b1, 32'(4 * i), mem_word(32'(4 * i))}) begin
                n_bad++; $display("FAIL bp_pop_%0d got v=%b %h/%h exp v=1 pc %h", i, ins_valid, ins, ins_pc, 32'(4 * i));
            end
            if (req_valid && req_ready && !have_req) begin first_req = req_addr; have_req = 1'b1; end
            step();
        end
        n_cmp++; if ({have_req, first_req} !== {1'b1, 32'h10}) begin n_bad++; $display("FAIL bp_resume_addr got seen=%b %h exp 00000010", have_req, first_req); end
        n_cmp++; if ({ins_valid, ins_pc} !== {1'b1, 32'h10}) begin n_bad++; $display("FAIL bp_after_pops got v=%b pc %h exp v=1 00000010", ins_valid, ins_pc); end
    endtask

    task automatic test_redirect_flush;
        logic        found;
        logic        have_req;
        logic [31:0] first_req;
        lat = 3; req_ready = 1'b1; ins_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) step();
        n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL rd_cap_req_valid got %b exp 0", req_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL rd_flushed got %b exp 0", ins_valid); end
        found = 1'b0; have_req = 1'b0; first_req = 32'h0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (req_valid && req_ready && !have_req) begin first_req = req_addr; have_req = 1'b1; end
            if (ins_valid) found = 1'b1;
            else step();
        end
        n_cmp++; if ({have_req, first_req} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL rd_first_req got seen=%b %h exp 00000100", have_req, first_req); end
        n_cmp++; if ({found, ins_pc, ins} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
            n_bad++; $display("FAIL rd_first_ins got found=%b %h/%h exp %h/00000100", found, ins, ins_pc, mem_word(32'h100));
        end
    endtask

    task automatic test_req_stall;
        lat = 1; req_ready = 1'b0; ins_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL stall_hold_%0d got v=%b %h exp v=1 00000000", i, req_valid, req_addr); end
            step();
        end
        req_ready = 1'b1;
        #1;
        step();
        n_cmp++; if (req_addr !== 32'h4) begin n_bad++; $display("FAIL stall_advance got %h exp 00000004", req_addr); end
        step();
        n_cmp++; if (req_addr !== 32'h8) begin n_bad++; $display("FAIL stall_advance2 got %h exp 00000008", req_addr); end
    endtask

    task automatic test_wrap;
        logic found;
        lat = 1; req_ready = 1'b1; ins_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_redirect_gate got %b exp 0", req_valid); end
        step();
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin n_bad++; $display("FAIL wrap_addr0 got v=%b %h exp v=1 fffffffc", req_valid, req_addr); end
        step();
        n_cmp++; if (req_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr1 got %h exp 00000000", req_addr); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (ins_valid) found = 1'b1;
            else step();
        end
        n_cmp++; if ({found, ins_pc, ins} !== {1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)}) begin
            n_bad++; $display("FAIL wrap_ins0 got found=%b %h/%h exp pc fffffffc", found, ins, ins_pc);
        end
        step();
        n_cmp++; if ({ins_valid, ins_pc, ins} !== {1'b1, 32'h0, 32'h0070_0093}) begin
            n_bad++; $display("FAIL wrap_ins1 got v=%b %h/%h exp v=1 00700093/00000000", ins_valid, ins, ins_pc);
        end
    endtask

    task automatic test_reset_mid;
        logic found;
        lat = 1; req_ready = 1'b1; ins_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if ({ins_valid, ins_pc} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL mid_pre_valid got v=%b pc %h exp v=1 00000000", ins_valid, ins_pc); end
        rst = 1'b1;
        step();
        n_cmp++; if ({ins_valid, ins, ins_pc} !== {1'b0, 32'h0000_0013, 32'h0}) begin
            n_bad++; $display("FAIL mid_reset_out got v=%b %h/%h exp v=0 00000013/00000000", ins_valid, ins, ins_pc);
        end
        rst = 1'b0;
        ins_ready = 1'b1;
        #1;
        n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL mid_restart_req got v=%b %h exp v=1 00000000", req_valid, req_addr); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (ins_valid) found = 1'b1;
            else step();
        end
        n_cmp++; if ({found, ins_pc, ins} !== {1'b1, 32'h0, 32'h0070_0093}) begin
            n_bad++; $display("FAIL mid_restart_ins got found=%b %h/%h exp 00700093/00000000", found, ins, ins_pc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_req_stall();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
